// File: rtl/fft_frame_feeder_if.sv
// Bundle of host-write, frame-request and FFT-stream signals around fft_frame_feeder.
// The master modport is the feeder itself; the slave modport is the host/FFT side.
interface fft_frame_feeder_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
);
  // Handshake: go is a level request taken only in IDLE (never queued);
  // next_data is a ready level from the FFT, looked at only while waiting;
  // once Data_Start fires, In_Stream carries one valid sample every clock
  // with no back-pressure, and done marks the cycle after the last one.
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              go;
  logic              mode_in;
  logic              next_data;
  logic [DATA_W-1:0] In_Stream;
  logic              Data_Start;
  logic              Mode;
  logic              busy;
  logic              done;
  logic              wr_err;
  logic [1:0]        state_dbg;

  modport master (
    input  wr_en, wr_addr, wr_data, go, mode_in, next_data,
    output In_Stream, Data_Start, Mode, busy, done, wr_err, state_dbg
  );

  modport slave (
    output wr_en, wr_addr, wr_data, go, mode_in, next_data,
    input  In_Stream, Data_Start, Mode, busy, done, wr_err, state_dbg
  );
endinterface

// File: rtl/fft_frame_feeder.sv
// Frame buffer that streams one FRAME_LEN-sample frame into the FFT on request.
// Optional macro FEEDER_BITREV_EN streams the buffer in bit-reversed index order.
module fft_frame_feeder #(
  parameter int DATA_W    = 32,
  parameter int FRAME_LEN = 64,
  parameter int ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              rst,
  fft_frame_feeder_if.master bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RDY = 2'd1,
    SEND     = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] mem [FRAME_LEN];

  // Maps the stream position to the buffer slot it is read from.
  function automatic logic [ADDR_W-1:0] rd_map(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
`ifdef FEEDER_BITREV_EN
    for (int b = 0; b < ADDR_W; b++) begin
      r[b] = a[ADDR_W-1-b];
    end
`else
    r = a;
`endif
    return r;
  endfunction

  // Buffer is deliberately not reset; the host reloads it after reset.
  always_ff @(posedge clk) begin
    if (bus.wr_en && (state == IDLE)) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      bus.In_Stream  <= '0;
      bus.Data_Start <= 1'b0;
      bus.Mode       <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.wr_err     <= 1'b0;
    end else begin
      bus.Data_Start <= 1'b0;
      bus.done       <= 1'b0;
      bus.wr_err     <= bus.wr_en && (state != IDLE);
      case (state)
        IDLE: begin
          if (bus.go) begin
            state    <= WAIT_RDY;
            bus.Mode <= bus.mode_in;
            bus.busy <= 1'b1;
          end
        end
        WAIT_RDY: begin
          if (bus.next_data) begin
            state          <= SEND;
            bus.Data_Start <= 1'b1;
            bus.In_Stream  <= mem[rd_map('0)];
            idx            <= ADDR_W'(1);
          end
        end
        SEND: begin
          // idx wraps back to zero once the last sample has been driven.
          if (idx == '0) begin
            state         <= IDLE;
            bus.In_Stream <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
          end else begin
            bus.In_Stream <= mem[rd_map(idx)];
            idx           <= idx + ADDR_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  assign bus.state_dbg = state;

endmodule
